// File: rtl/memory_inhibit_sequencer.sv
// Core-memory write/restore sequencer: runs one destructive-read then restore/write cycle on the
// selected memory module (a-d). It drives the read, sense-strobe, write and inhibit lines, and it
// captures and parity-checks the sensed word.
module memory_inhibit_sequencer #(
   parameter int unsigned WIDTH        = 13,
   parameter int unsigned READ_CYCLES  = 3,
   parameter int unsigned WRITE_CYCLES = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MSTART,
   input  logic [1:0]               MSEL,
   input  logic                     WRMODE,
   input  logic [WIDTH-1:0]         WDATA,
   input  logic [WIDTH-1:0]         SADATA,
   input  logic                     SAPAR,
   output logic                     BUSY,
   output logic [3:0]               RDRV,
   output logic [3:0]               SASTB,
   output logic [3:0]               WDRV,
   output logic [4*(WIDTH+1)-1:0]   INH,
   output logic [WIDTH-1:0]         RDATA,
   output logic                     PERR,
   output logic                     DONE
);

   localparam int unsigned SliceW = WIDTH + 1;
   localparam int unsigned MaxCyc = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
   // The counter only ever holds values 0 .. MaxCyc-1.
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
   localparam logic [CntW-1:0] ReadLoad  = CntW'(READ_CYCLES - 1);
   localparam logic [CntW-1:0] WriteLoad = CntW'(WRITE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StStrobe,
      StSetup,
      StWrite,
      StRecover
   } stateT;

   stateT               stateQ, stateD;
   logic [CntW-1:0]     cntQ, cntD;
   logic [1:0]          selQ, selD;
   logic                modeQ, modeD;
   logic [WIDTH-1:0]    wdataQ, wdataD;
   logic [SliceW-1:0]   storeQ, storeD;
   logic [WIDTH-1:0]    rdataQ, rdataD;
   logic                perrQ, perrD;

   logic                busyQ, busyD;
   logic [3:0]          rdrvQ, rdrvD;
   logic [3:0]          sastbQ, sastbD;
   logic [3:0]          wdrvQ, wdrvD;
   logic [4*SliceW-1:0] inhQ, inhD;
   logic                doneQ, doneD;

   logic [3:0]          selHot;
   logic                inhPhase;

   // Next-state sequencing, request latching and sense-word capture.
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      selD   = selQ;
      modeD  = modeQ;
      wdataD = wdataQ;
      storeD = storeQ;
      rdataD = rdataQ;
      perrD  = perrQ;

      case (stateQ)
         StIdle: begin
            if (MSTART) begin
               stateD = StRead;
               cntD   = ReadLoad;
               selD   = MSEL;
               modeD  = WRMODE;
               wdataD = WDATA;
            end
         end
         StRead: begin
            if (cntQ == '0) begin
               stateD = StStrobe;
            end else begin
               cntD = cntQ - CntW'(1);
            end
         end
         StStrobe: begin
            stateD = StSetup;
            rdataD = SADATA;
            // Odd parity over {parity, data} is correct.
            perrD  = ~(^{SAPAR, SADATA});
            // A generated parity bit makes the written word odd parity.
            storeD = modeQ ? {~^wdataQ, wdataQ} : {SAPAR, SADATA};
         end
         StSetup: begin
            stateD = StWrite;
            cntD   = WriteLoad;
         end
         StWrite: begin
            if (cntQ == '0) begin
               stateD = StRecover;
            end else begin
               cntD = cntQ - CntW'(1);
            end
         end
         StRecover: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // Next values of the registered drive, inhibit and status outputs.
   always_comb begin
      busyD    = (stateD != StIdle);
      selHot   = 4'b0001 << selD;
      rdrvD    = (stateD == StRead)   ? selHot : 4'b0000;
      sastbD   = (stateD == StStrobe) ? selHot : 4'b0000;
      wdrvD    = (stateD == StWrite)  ? selHot : 4'b0000;
      doneD    = (stateQ == StRecover);
      inhPhase = (stateD == StSetup) || (stateD == StWrite) || (stateD == StRecover);
      inhD     = '0;
      // A 0 bit is stored by inhibiting it, so the selected slice carries ~store.
      if (inhPhase) begin
         for (int m = 0; m < 4; m++) begin
            if (selQ == 2'(m)) begin
               inhD[m*SliceW +: SliceW] = ~storeD;
            end
         end
      end
   end

   // State and output registers; reset abandons any cycle in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= StIdle;
         cntQ   <= '0;
         selQ   <= '0;
         modeQ  <= 1'b0;
         wdataQ <= '0;
         storeQ <= '0;
         rdataQ <= '0;
         perrQ  <= 1'b0;
         busyQ  <= 1'b0;
         rdrvQ  <= '0;
         sastbQ <= '0;
         wdrvQ  <= '0;
         inhQ   <= '0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         selQ   <= selD;
         modeQ  <= modeD;
         wdataQ <= wdataD;
         storeQ <= storeD;
         rdataQ <= rdataD;
         perrQ  <= perrD;
         busyQ  <= busyD;
         rdrvQ  <= rdrvD;
         sastbQ <= sastbD;
         wdrvQ  <= wdrvD;
         inhQ   <= inhD;
         doneQ  <= doneD;
      end
   end

   assign BUSY  = busyQ;
   assign RDRV  = rdrvQ;
   assign SASTB = sastbQ;
   assign WDRV  = wdrvQ;
   assign INH   = inhQ;
   assign RDATA = rdataQ;
   assign PERR  = perrQ;
   assign DONE  = doneQ;

endmodule

// File: tb/tb_memory_inhibit_sequencer.sv
// Directed bench for memory_inhibit_sequencer: default instance plus a READ=1/WRITE=5 instance.
module tb_memory_inhibit_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        mstart, mstart2;
   logic [1:0]  msel;
   logic        wrmode;
   logic [12:0] wdata, sadata;
   logic        sapar;

   logic        busy, perr, done;
   logic [3:0]  rdrv, sastb, wdrv;
   logic [55:0] inh;
   logic [12:0] rdata;

   logic        busyB, perrB, doneB;
   logic [3:0]  rdrvB, sastbB, wdrvB;
   logic [55:0] inhB;
   logic [12:0] rdataB;

   int nCheck = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   memory_inhibit_sequencer #(.WIDTH(13), .READ_CYCLES(3), .WRITE_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .MSTART(mstart), .MSEL(msel), .WRMODE(wrmode),
      .WDATA(wdata), .SADATA(sadata), .SAPAR(sapar), .BUSY(busy), .RDRV(rdrv),
      .SASTB(sastb), .WDRV(wdrv), .INH(inh), .RDATA(rdata), .PERR(perr), .DONE(done)
   );

   memory_inhibit_sequencer #(.WIDTH(13), .READ_CYCLES(1), .WRITE_CYCLES(5)) dutB (
      .clk(clk), .reset(reset), .MSTART(mstart2), .MSEL(msel), .WRMODE(wrmode),
      .WDATA(wdata), .SADATA(sadata), .SAPAR(sapar), .BUSY(busyB), .RDRV(rdrvB),
      .SASTB(sastbB), .WDRV(wdrvB), .INH(inhB), .RDATA(rdataB), .PERR(perrB), .DONE(doneB)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCheck++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkIdle(input string tag);
      chk({tag, " BUSY"}, 64'(busy), 64'd0);
      chk({tag, " DONE"}, 64'(done), 64'd0);
   endtask

   // Starts a cycle from the current cycle (edge 0 follows) and checks cycles 1..10.
   // Returns in cycle 10 (the DONE cycle) without stepping past it.
   task automatic runCycle(input logic [1:0] sel, input logic mode, input logic [12:0] wd,
                           input logic [12:0] sd, input logic sp, input logic [13:0] slice,
                           input logic [12:0] expRdata, input logic expPerr,
                           input logic [10:0] startMask, input string name);
      logic [3:0]  oh;
      logic [63:0] inhExp;
      oh     = 4'b0001 << sel;
      inhExp = 64'(slice) << (int'(sel) * 14);
      mstart = 1'b1;
      msel   = sel;
      wrmode = mode;
      wdata  = wd;
      sadata = ~sd;
      sapar  = ~sp;
      step();
      for (int c = 1; c <= 10; c++) begin
         mstart = startMask[c];
         msel   = ~sel;
         wrmode = ~mode;
         wdata  = ~wd;
         sadata = (c == 4) ? sd : ~sd;
         sapar  = (c == 4) ? sp : ~sp;
         chk($sformatf("%s c%0d RDRV", name, c), 64'(rdrv),
             (c >= 1 && c <= 3) ? 64'(oh) : 64'd0);
         chk($sformatf("%s c%0d SASTB", name, c), 64'(sastb), (c == 4) ? 64'(oh) : 64'd0);
         chk($sformatf("%s c%0d WDRV", name, c), 64'(wdrv),
             (c >= 6 && c <= 8) ? 64'(oh) : 64'd0);
         chk($sformatf("%s c%0d INH", name, c), 64'(inh),
             (c >= 5 && c <= 9) ? inhExp : 64'd0);
         chk($sformatf("%s c%0d DONE", name, c), 64'(done), (c == 10) ? 64'd1 : 64'd0);
         chk($sformatf("%s c%0d BUSY", name, c), 64'(busy), (c <= 9) ? 64'd1 : 64'd0);
         if (c < 10) step();
      end
      chk({name, " RDATA"}, 64'(rdata), 64'(expRdata));
      chk({name, " PERR"}, 64'(perr), 64'(expPerr));
      mstart = 1'b0;
   endtask

   initial begin
      int wcount;

      // Reset with MSTART high on both instances: reset must win.
      reset   = 1'b1;
      mstart  = 1'b1;
      mstart2 = 1'b1;
      msel    = 2'd0;
      wrmode  = 1'b0;
      wdata   = 13'h0;
      sadata  = 13'h0;
      sapar   = 1'b0;
      step();
      step();
      chk("rst BUSY", 64'(busy), 64'd0);
      chk("rst RDRV", 64'(rdrv), 64'd0);
      chk("rst SASTB", 64'(sastb), 64'd0);
      chk("rst WDRV", 64'(wdrv), 64'd0);
      chk("rst INH", 64'(inh), 64'd0);
      chk("rst RDATA", 64'(rdata), 64'd0);
      chk("rst PERR", 64'(perr), 64'd0);
      chk("rst DONE", 64'(done), 64'd0);
      chk("rst BUSYB", 64'(busyB), 64'd0);
      mstart  = 1'b0;
      mstart2 = 1'b0;
      reset   = 1'b0;
      step();
      chkIdle("postrst");

      // Restore on module b; 0x0A5C has six ones and SAPAR=0, so the total is even -> PERR.
      // INH slice1 = ~{0,0x0A5C} = 0x35A3.
      runCycle(2'd1, 1'b0, 13'h1234, 13'h0A5C, 1'b0, 14'h35A3, 13'h0A5C, 1'b1, 11'd0, "restB");
      step();
      chkIdle("restB after");

      // Same word with SAPAR=1 is odd -> no error; ~{1,0x0A5C} = 0x15A3. Start pulses at 3 and 7.
      runCycle(2'd0, 1'b0, 13'h0000, 13'h0A5C, 1'b1, 14'h15A3, 13'h0A5C, 1'b0,
               11'b000_1000_1000, "ignA");
      step();
      chkIdle("ignA after");

      // Write 0x1FFF (13 ones) on module d: parity bit 0, stored {0,1FFF}, INH = 0x2000.
      // Sensed 0x0123 (four ones) with SAPAR=0 -> PERR.
      runCycle(2'd3, 1'b1, 13'h1FFF, 13'h0123, 1'b0, 14'h2000, 13'h0123, 1'b1, 11'd0, "wrD");
      step();
      chkIdle("wrD after");

      // Parity error on module c; restore writes it back unchanged: ~{1,0x0001} = 0x1FFE.
      runCycle(2'd2, 1'b0, 13'h1555, 13'h0001, 1'b1, 14'h1FFE, 13'h0001, 1'b1, 11'd0, "perrC");
      step();
      chkIdle("perrC after");

      // MSTART held through DONE: second cycle starts in the DONE cycle, DONE again at 20.
      // Write 0x0003: parity bit 1, ~{1,0x0003} = 0x1FFC. Sensed 0x0007, SAPAR=0 -> odd, ok.
      runCycle(2'd2, 1'b1, 13'h0003, 13'h0007, 1'b0, 14'h1FFC, 13'h0007, 1'b0,
               11'b011_1111_1110, "b2b1");
      // Restore 0x1000, SAPAR=0 -> odd, ok; ~{0,0x1000} = 0x2FFF.
      runCycle(2'd1, 1'b0, 13'h0000, 13'h1000, 1'b0, 14'h2FFF, 13'h1000, 1'b0, 11'd0, "b2b2");
      step();
      chkIdle("b2b after");

      // Reset during WRITE at cycle 7; 0x0A5C with SAPAR=0 sets PERR, which reset must clear.
      mstart = 1'b1;
      msel   = 2'd1;
      wrmode = 1'b0;
      sadata = 13'h0A5C;
      sapar  = 1'b0;
      step();
      mstart = 1'b0;
      for (int c = 2; c <= 7; c++) step();
      chk("rstmid c7 WDRV", 64'(wdrv), 64'h2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rstmid c8 BUSY", 64'(busy), 64'd0);
      chk("rstmid c8 WDRV", 64'(wdrv), 64'd0);
      chk("rstmid c8 INH", 64'(inh), 64'd0);
      chk("rstmid c8 RDRV", 64'(rdrv), 64'd0);
      chk("rstmid c8 RDATA", 64'(rdata), 64'd0);
      chk("rstmid c8 PERR", 64'(perr), 64'd0);
      chk("rstmid c8 DONE", 64'(done), 64'd0);
      step();
      chkIdle("rstmid c9");
      // Start at cycle 9 finishes at cycle 19. 0x0F0F (eight ones) + SAPAR=1 is odd, ok.
      // ~{1,0x0F0F} = 0x10F0.
      runCycle(2'd0, 1'b0, 13'h0000, 13'h0F0F, 1'b1, 14'h10F0, 13'h0F0F, 1'b0, 11'd0, "rstrun");
      step();
      chkIdle("rstrun after");

      // READ_CYCLES=1, WRITE_CYCLES=5 on module c: DONE 10 cycles after accept, WDRV high 5 cycles.
      mstart2 = 1'b1;
      msel    = 2'd2;
      step();
      mstart2 = 1'b0;
      wcount  = 0;
      for (int c = 1; c <= 10; c++) begin
         chk($sformatf("swp c%0d RDRV", c), 64'(rdrvB), (c == 1) ? 64'h4 : 64'd0);
         chk($sformatf("swp c%0d SASTB", c), 64'(sastbB), (c == 2) ? 64'h4 : 64'd0);
         chk($sformatf("swp c%0d WDRV", c), 64'(wdrvB), (c >= 4 && c <= 8) ? 64'h4 : 64'd0);
         chk($sformatf("swp c%0d DONE", c), 64'(doneB), (c == 10) ? 64'd1 : 64'd0);
         if (wdrvB != 4'b0000) wcount++;
         if (c < 10) step();
      end
      chk("swp WDRV cycles", 64'(wcount), 64'd5);
      chk("swp A idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nCheck, nFail);
      $finish;
   end

endmodule
